dmux_issue_ctrl: RTL and testbench

- Upstream issue controller for the pipelined demultiplexer (dmux_lfmr).
- The demux samples `sel` at every pipeline depth without registering it, so `sel` must stay stable for LATENCY cycles after an issue.
- This block accepts (sel, data) transactions over a valid/ready handshake and drives the demux `sel`/`in`. It holds `sel` until the transaction has drained, and emits a one-hot `out_valid` aligned with the demux output.

---
 rtl/dmux_issue_ctrl.sv | 153 +++++++++++++++
 tb/tb_dmux_issue_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmux_issue_ctrl.sv
// Upstream issue controller for dmux_lfmr: freezes sel/in while a transaction drains through the demux
// and raises a one-hot out_valid aligned with the demux output. Optional macro: DMUX_ISSUE_SAME_SEL_STREAM_EN.
//
// state | meaning
// IDLE  | ready for a new transaction
// HOLD  | sel/in frozen while the last issue drains through the demux pipeline

module dmux_issue_ctrl #(
  parameter int WIDTH        = 8,
  parameter int OUTPUT_COUNT = 4,
  parameter int LATENCY      = 2,
  parameter int SEL_W        = $clog2(OUTPUT_COUNT) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [SEL_W-1:0]        s_sel,
  input  logic [WIDTH-1:0]        s_data,
  output logic [SEL_W-1:0]        dmux_sel,
  output logic [WIDTH-1:0]        dmux_in,
  output logic [OUTPUT_COUNT-1:0] out_valid,
  output logic                    err_oor,
  output logic                    busy
);

  localparam int CNT_W = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
  localparam int TAG_D = (LATENCY < 1) ? 1 : LATENCY;
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(LATENCY);
  localparam logic [SEL_W-1:0] SEL_LIMIT = SEL_W'(OUTPUT_COUNT);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t                         state_q, state_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [SEL_W-1:0]               dmux_sel_q, dmux_sel_d;
  logic [WIDTH-1:0]               dmux_in_q, dmux_in_d;
  logic [OUTPUT_COUNT-1:0]        out_valid_q, out_valid_d;
  logic                           err_oor_q, err_oor_d;
  logic                           s_ready_q, s_ready_d;
  logic [TAG_D-1:0]               tag_vld_q, tag_vld_d;
  logic [TAG_D-1:0][SEL_W-1:0]    tag_sel_q, tag_sel_d;

  logic             acc;
  logic             in_range;
  logic             acc_in;
  logic             acc_oor;
  logic             last_vld;
  logic [SEL_W-1:0] last_sel;

`ifdef DMUX_ISSUE_SAME_SEL_STREAM_EN
  // While holding, a transaction for the same output may join the stream.
  assign s_ready = s_ready_q | ((state_q == ST_HOLD) & s_valid & (s_sel == dmux_sel_q));
`else
  assign s_ready = s_ready_q;
`endif

  assign acc      = s_valid & s_ready;
  assign in_range = (s_sel < SEL_LIMIT);
  assign acc_in   = acc & in_range;
  assign acc_oor  = acc & ~in_range;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dmux_sel_d = dmux_sel_q;
    dmux_in_d  = dmux_in_q;
    case (state_q)
      ST_IDLE: begin
        if (acc_in) begin
          dmux_sel_d = s_sel;
          dmux_in_d  = s_data;
          if (LATENCY > 0) begin
            state_d = ST_HOLD;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      ST_HOLD: begin
        if (acc_in) begin
          dmux_in_d = s_data;
          cnt_d     = CNT_LOAD;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    err_oor_d = acc_oor;
    s_ready_d = (state_d == ST_IDLE);
  end

  // Tag pipeline mirrors the demux depth so out_valid lands with the data.
  always_comb begin
    tag_vld_d = '0;
    tag_sel_d = tag_sel_q;
    last_vld  = 1'b0;
    last_sel  = '0;
    if (LATENCY > 0) begin
      for (int i = TAG_D - 1; i > 0; i--) begin
        tag_vld_d[i] = tag_vld_q[i-1];
        tag_sel_d[i] = tag_sel_q[i-1];
      end
      tag_vld_d[0] = acc_in;
      tag_sel_d[0] = s_sel;
      last_vld     = tag_vld_q[TAG_D-1];
      last_sel     = tag_sel_q[TAG_D-1];
    end else begin
      last_vld = acc_in;
      last_sel = s_sel;
    end
    out_valid_d = '0;
    for (int i = 0; i < OUTPUT_COUNT; i++) begin
      out_valid_d[i] = last_vld & (last_sel == SEL_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      dmux_sel_q  <= '0;
      dmux_in_q   <= '0;
      out_valid_q <= '0;
      err_oor_q   <= 1'b0;
      s_ready_q   <= 1'b0;
      tag_vld_q   <= '0;
      tag_sel_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dmux_sel_q  <= dmux_sel_d;
      dmux_in_q   <= dmux_in_d;
      out_valid_q <= out_valid_d;
      err_oor_q   <= err_oor_d;
      s_ready_q   <= s_ready_d;
      tag_vld_q   <= tag_vld_d;
      tag_sel_q   <= tag_sel_d;
    end
  end

  assign dmux_sel  = dmux_sel_q;
  assign dmux_in   = dmux_in_q;
  assign out_valid = out_valid_q;
  assign err_oor   = err_oor_q;
  assign busy      = (state_q == ST_HOLD) | (|tag_vld_q);

endmodule

// File: tb/tb_dmux_issue_ctrl.sv
// Bench for dmux_issue_ctrl: LATENCY=2 and LATENCY=0 instances checked against a timestamp-based model,
// plus a directed vector table and hand sequences for reset, streaming and back-to-back issue.

module tb_dmux_issue_ctrl;

  localparam int WIDTH = 8;
  localparam int OC    = 4;
  localparam int SEL_W = 3;
`ifdef DMUX_ISSUE_SAME_SEL_STREAM_EN
  localparam bit STREAM = 1'b1;
`else
  localparam bit STREAM = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      rst;
  logic [1:0]                s_valid;
  logic [1:0][SEL_W-1:0]     s_sel;
  logic [1:0][WIDTH-1:0]     s_data;
  logic [1:0]                s_ready;
  logic [1:0][SEL_W-1:0]     dmux_sel;
  logic [1:0][WIDTH-1:0]     dmux_in;
  logic [1:0][OC-1:0]        out_valid;
  logic [1:0]                err_oor;
  logic [1:0]                busy;

  dmux_issue_ctrl #(.WIDTH(WIDTH), .OUTPUT_COUNT(OC), .LATENCY(2)) u_lat2 (
    .clk(clk), .rst(rst), .s_valid(s_valid[0]), .s_ready(s_ready[0]), .s_sel(s_sel[0]),
    .s_data(s_data[0]), .dmux_sel(dmux_sel[0]), .dmux_in(dmux_in[0]), .out_valid(out_valid[0]),
    .err_oor(err_oor[0]), .busy(busy[0])
  );

  dmux_issue_ctrl #(.WIDTH(WIDTH), .OUTPUT_COUNT(OC), .LATENCY(0)) u_lat0 (
    .clk(clk), .rst(rst), .s_valid(s_valid[1]), .s_ready(s_ready[1]), .s_sel(s_sel[1]),
    .s_data(s_data[1]), .dmux_sel(dmux_sel[1]), .dmux_in(dmux_in[1]), .out_valid(out_valid[1]),
    .err_oor(err_oor[1]), .busy(busy[1])
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst%0d t=%0t got=%0h want=%0h", name, inst, $time, act, exp);
    end
  endtask

  // Reference model: every in-range accept at edge n is stamped with a due edge n+LATENCY;
  // further accepts are blocked until edge n+LATENCY+1 (unless same-sel streaming applies).
  int                ncyc = 0;
  bit                started [2];
  int                next_ok [2];
  int                last_due[2];
  int                sch_due [2][8];
  int                sch_sel [2][8];
  logic [SEL_W-1:0]  m_sel   [2];
  logic [WIDTH-1:0]  m_data  [2];
  bit                m_err   [2];
  logic [OC-1:0]     m_ov    [2];

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  function automatic bit m_ready(input int i, input int n);
    if (!started[i]) return 1'b0;
    if (n >= next_ok[i]) return 1'b1;
    return STREAM && s_valid[i] && (s_sel[i] == m_sel[i]);
  endfunction

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        started[i]  = 1'b0;
        next_ok[i]  = 0;
        last_due[i] = -1;
        for (int j = 0; j < 8; j++) sch_due[i][j] = -1;
        m_sel[i]  = '0;
        m_data[i] = '0;
        m_err[i]  = 1'b0;
        m_ov[i]   = '0;
      end else begin
        bit acc;
        int due;
        acc = s_valid[i] && m_ready(i, ncyc);
        m_err[i] = 1'b0;
        if (acc) begin
          if (int'(s_sel[i]) < OC) begin
            due = ncyc + lat_of(i);
            m_sel[i]  = s_sel[i];
            m_data[i] = s_data[i];
            sch_due[i][due % 8] = due;
            sch_sel[i][due % 8] = int'(s_sel[i]);
            next_ok[i]  = due + 1;
            last_due[i] = due;
          end else begin
            m_err[i] = 1'b1;
          end
        end
        m_ov[i] = '0;
        if (sch_due[i][ncyc % 8] == ncyc) m_ov[i][sch_sel[i][ncyc % 8]] = 1'b1;
        started[i] = 1'b1;
      end
    end
    ncyc++;
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk("m_ready",    i, 32'(s_ready[i]),   32'(m_ready(i, ncyc)));
      chk("m_dmux_sel", i, 32'(dmux_sel[i]),  32'(m_sel[i]));
      chk("m_dmux_in",  i, 32'(dmux_in[i]),   32'(m_data[i]));
      chk("m_out_valid",i, 32'(out_valid[i]), 32'(m_ov[i]));
      chk("m_err_oor",  i, 32'(err_oor[i]),   32'(m_err[i]));
      chk("m_busy",     i, 32'(busy[i]),      32'((ncyc < next_ok[i]) || (last_due[i] >= ncyc)));
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    #2;
    if (chk_en) check_all();
  end

  typedef struct {
    logic             v;
    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] data;
    logic             rdy;
    logic [SEL_W-1:0] dsel;
    logic [WIDTH-1:0] din;
    logic [OC-1:0]    ov;
    logic             err;
    logic             bsy;
  } vec_t;

  vec_t tbl[17];

  initial begin
    logic [OC-1:0] ov_seen;
    logic          exp_rdy;
    int            acc_at[3];
    int            na;

    tbl[0]  = '{1'b1, 3'd2, 8'hA5, 1'b0, 3'd2, 8'hA5, 4'b0000, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd2, 8'hA5, 4'b0000, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 8'hA5, 4'b0100, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 8'hA5, 4'b0000, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 3'd1, 8'h11, 1'b0, 3'd1, 8'h11, 4'b0000, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 3'd3, 8'h33, 1'b0, 3'd1, 8'h11, 4'b0000, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 3'd3, 8'h33, 1'b1, 3'd1, 8'h11, 4'b0010, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 3'd3, 8'h33, 1'b0, 3'd3, 8'h33, 4'b0000, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd3, 8'h33, 4'b0000, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 8'h33, 4'b1000, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 3'd5, 8'h55, 1'b1, 3'd3, 8'h33, 4'b0000, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 8'h33, 4'b0000, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 3'd4, 8'h44, 1'b1, 3'd3, 8'h33, 4'b0000, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 8'h33, 4'b0000, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 3'd0, 8'h5C, 1'b0, 3'd0, 8'h5C, 4'b0000, 1'b0, 1'b1};
    tbl[15] = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h5C, 4'b0000, 1'b0, 1'b1};
    tbl[16] = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 8'h5C, 4'b0001, 1'b0, 1'b0};

    rst = 1'b1;
    s_valid = '0;
    s_sel = '0;
    s_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("rst_ready", 0, 32'(s_ready[0]), 32'd0);
    chk("rst_ov",    0, 32'(out_valid[0]), 32'd0);
    chk("rst_busy",  0, 32'(busy[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_exit_ready", 0, 32'(s_ready[0]), 32'd1);

    // Directed vectors on the LATENCY=2 instance
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      s_valid[0] = tbl[k].v;
      s_sel[0]   = tbl[k].sel;
      s_data[0]  = tbl[k].data;
      @(posedge clk);
      #1;
      exp_rdy = tbl[k].rdy | (STREAM & ~tbl[k].rdy & tbl[k].v & (tbl[k].sel == tbl[k].dsel));
      chk("vec_ready",    k, 32'(s_ready[0]),   32'(exp_rdy));
      chk("vec_dmux_sel", k, 32'(dmux_sel[0]),  32'(tbl[k].dsel));
      chk("vec_dmux_in",  k, 32'(dmux_in[0]),   32'(tbl[k].din));
      chk("vec_out_valid",k, 32'(out_valid[0]), 32'(tbl[k].ov));
      chk("vec_err_oor",  k, 32'(err_oor[0]),   32'(tbl[k].err));
      chk("vec_busy",     k, 32'(busy[0]),      32'(tbl[k].bsy));
    end

    // Reset one cycle after an accept: the in-flight transaction must vanish
    @(negedge clk);
    s_valid[0] = 1'b1;
    s_sel[0]   = 3'd0;
    s_data[0]  = 8'h77;
    @(negedge clk);
    s_valid[0] = 1'b0;
    rst = 1'b1;
    ov_seen = '0;
    repeat (2) begin
      @(posedge clk);
      #1;
      ov_seen = ov_seen | out_valid[0];
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    ov_seen = ov_seen | out_valid[0];
    chk("rstx_ready",    0, 32'(s_ready[0]),  32'd1);
    chk("rstx_dmux_sel", 0, 32'(dmux_sel[0]), 32'd0);
    chk("rstx_dmux_in",  0, 32'(dmux_in[0]),  32'd0);
    chk("rstx_err",      0, 32'(err_oor[0]),  32'd0);
    chk("rstx_busy",     0, 32'(busy[0]),     32'd0);
    repeat (3) begin
      @(posedge clk);
      #1;
      ov_seen = ov_seen | out_valid[0];
    end
    chk("rst_drops_ov", 0, 32'(ov_seen), 32'd0);

    // Three same-select transactions with valid held
    @(negedge clk);
    s_valid[0] = 1'b1;
    s_sel[0]   = 3'd1;
    s_data[0]  = 8'hC0;
    na = 0;
    for (int k = 0; k < 30 && na < 3; k++) begin
      #3;
      if (s_ready[0]) begin
        acc_at[na] = k;
        na++;
      end
      @(negedge clk);
      s_data[0] = s_data[0] + 8'd1;
    end
    s_valid[0] = 1'b0;
    chk("stream_accepts", 0, 32'(na), 32'd3);
    if (na == 3) begin
      chk("stream_gap1", 0, 32'(acc_at[1] - acc_at[0]), STREAM ? 32'd1 : 32'd3);
      chk("stream_gap2", 0, 32'(acc_at[2] - acc_at[1]), STREAM ? 32'd1 : 32'd3);
    end
    repeat (4) @(negedge clk);

    // LATENCY=0: back-to-back issue to every output
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      s_valid[1] = 1'b1;
      s_sel[1]   = SEL_W'(k);
      s_data[1]  = 8'h60 + 8'(k);
      @(posedge clk);
      #1;
      chk("l0_ready",     k, 32'(s_ready[1]),   32'd1);
      chk("l0_out_valid", k, 32'(out_valid[1]), 32'(1 << k));
      chk("l0_dmux_sel",  k, 32'(dmux_sel[1]),  32'(k));
    end
    @(negedge clk);
    s_valid[1] = 1'b0;

    // Random traffic on both instances, checked by the model every cycle
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < 2; i++) begin
        s_valid[i] = ($urandom_range(0, 3) != 0);
        s_sel[i]   = SEL_W'($urandom_range(0, 5));
        s_data[i]  = WIDTH'($urandom);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    s_valid = '0;
    repeat (6) @(negedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
